// File: rtl/decoder_stage_controller_pkg.sv
// Shared decoder parameters package.
// Holds the stage broadcast encoding seen by every processing unit (stage_in)
// and by the stage controller, plus small helpers used by the controller.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  // Width of the quiet-cycle counter; QUIESCE_CYCLES is limited to 1..15.
  localparam int QUIET_CNT_WIDTH = 4;

  typedef enum logic [STAGE_WIDTH-1:0] {
    IDLE                = 3'd0,
    MEASUREMENT_LOADING = 3'd1,
    SPREAD_CLUSTER      = 3'd2,
    SYNC_IS_ODD_CLUSTER = 3'd3,
    GROW_BOUNDARY       = 3'd4,
    RESULT_VALID        = 3'd5
  } stage_e;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/decoder_stage_controller_quiescence_counter.sv
// quiescence_counter
// Counts consecutive quiet (busy=0) cycles and flags the cycle in which the
// count reaches QUIESCE_CYCLES. The count restarts on any busy cycle, while
// clear is high, and after each completed quiet run.
// Ports:
//   clk   - clock
//   reset - synchronous, active-low reset
//   clear - hold count at zero (controller is not in a settling stage)
//   busy  - OR of PU activity this cycle
//   done  - this cycle completes QUIESCE_CYCLES consecutive quiet cycles
module quiescence_counter
  import decoder_stage_controller_pkg::*;
#(
  parameter int QUIESCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic done
);

  logic [QUIET_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    done  = 1'b0;
    cnt_d = cnt_q;
    if (clear || busy) begin
      cnt_d = '0;
    end else if (cnt_q == QUIET_CNT_WIDTH'(QUIESCE_CYCLES - 1)) begin
      // This quiet cycle is the QUIESCE_CYCLES-th one: end the run.
      done  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_stage_controller.sv
// decoder_stage_controller
// Sequences the decoder array through its stages and broadcasts the current
// stage to every processing unit. Settling stages end after QUIESCE_CYCLES
// consecutive quiet cycles; the grow loop ends when no odd clusters remain
// or MAX_ITERATION grow stages have been issued (timeout).
// All outputs come straight from registers.
// Ports:
//   clk               - clock
//   reset             - synchronous, active-low reset
//   start             - decode request, honoured only in IDLE
//   busy_any          - any PU processing or channel valid
//   odd_cluster_any   - any odd cluster not touching the boundary
//   result_ready      - consumer accepts the result
//   stage             - current stage encoding
//   result_valid      - decode finished, result stable
//   timeout           - gave up with odd clusters left (valid with result_valid)
//   iteration_counter - GROW_BOUNDARY stages issued in this decode
//   cycle_counter     - active decode cycles (saturating)
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int CODE_DISTANCE  = 5,
  parameter int QUIESCE_CYCLES = 3,
  parameter int MAX_ITERATION  = 2 * CODE_DISTANCE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   busy_any,
  input  logic                   odd_cluster_any,
  input  logic                   result_ready,
  output logic [STAGE_WIDTH-1:0] stage,
  output logic                   result_valid,
  output logic                   timeout,
  output logic [7:0]             iteration_counter,
  output logic [15:0]            cycle_counter
);

  stage_e      state_q, state_d;
  logic [7:0]  iter_q, iter_d;
  logic [15:0] cyc_q, cyc_d;
  logic        timeout_q, timeout_d;
  logic        quiet_clear;
  logic        quiet_done;

  // Quiet counting only runs in the two settling stages; anywhere else it is
  // held at zero, so it always starts from zero on stage entry.
  assign quiet_clear = !((state_q == SPREAD_CLUSTER) ||
                         (state_q == SYNC_IS_ODD_CLUSTER));

  quiescence_counter #(
    .QUIESCE_CYCLES(QUIESCE_CYCLES)
  ) u_quiescence_counter (
    .clk  (clk),
    .reset(reset),
    .clear(quiet_clear),
    .busy (busy_any),
    .done (quiet_done)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MEASUREMENT_LOADING;
          iter_d    = '0;
          cyc_d     = '0;
          timeout_d = 1'b0;
        end
      end

      MEASUREMENT_LOADING: begin
        cyc_d   = sat_inc16(cyc_q);
        state_d = SPREAD_CLUSTER;
      end

      SPREAD_CLUSTER: begin
        cyc_d = sat_inc16(cyc_q);
        if (quiet_done) state_d = SYNC_IS_ODD_CLUSTER;
      end

      SYNC_IS_ODD_CLUSTER: begin
        cyc_d = sat_inc16(cyc_q);
        if (quiet_done) begin
          // odd_cluster_any is only meaningful once the array has settled,
          // so it is sampled in the exit cycle.
          if (!odd_cluster_any) begin
            state_d   = RESULT_VALID;
            timeout_d = 1'b0;
          end else if (iter_q == 8'(MAX_ITERATION)) begin
            state_d   = RESULT_VALID;
            timeout_d = 1'b1;
          end else begin
            state_d = GROW_BOUNDARY;
          end
        end
      end

      GROW_BOUNDARY: begin
        cyc_d   = sat_inc16(cyc_q);
        iter_d  = iter_q + 8'd1;
        state_d = SPREAD_CLUSTER;
      end

      RESULT_VALID: begin
        // A start arriving with the handshake is dropped: we return to IDLE.
        if (result_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  assign stage             = state_q;
  assign result_valid      = (state_q == RESULT_VALID);
  assign timeout           = timeout_q;
  assign iteration_counter = iter_q;
  assign cycle_counter     = cyc_q;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Self-checking bench for decoder_stage_controller.
// Directed scenarios with fixed cycle-by-cycle expectations, followed by a
// randomized run compared every cycle against a behavioural model.
module tb_decoder_stage_controller;

  localparam int Q    = 3;
  localparam int MAXI = 2;

  // Stage numbers as defined for the decoder
  localparam int S_IDLE = 0, S_LOAD = 1, S_SPREAD = 2, S_SYNC = 3, S_GROW = 4, S_RV = 5;

  logic        clk = 1'b0;
  logic        reset, start, busy_any, odd_cluster_any, result_ready;
  logic [2:0]  stage;
  logic        result_valid, timeout;
  logic [7:0]  iteration_counter;
  logic [15:0] cycle_counter;

  decoder_stage_controller #(
    .CODE_DISTANCE (5),
    .QUIESCE_CYCLES(Q),
    .MAX_ITERATION (MAXI)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .busy_any         (busy_any),
    .odd_cluster_any  (odd_cluster_any),
    .result_ready     (result_ready),
    .stage            (stage),
    .result_valid     (result_valid),
    .timeout          (timeout),
    .iteration_counter(iteration_counter),
    .cycle_counter    (cycle_counter)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  int m_stage = 0, m_quiet = 0, m_iter = 0, m_cyc = 0;
  bit m_to = 0;

  int obs[0:63];
  int cidx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of the decoder as described by its rules.
  task automatic model_step(input bit rst, input bit st, input bit bsy,
                            input bit odd, input bit rdy);
    if (!rst) begin
      m_stage = S_IDLE; m_quiet = 0; m_iter = 0; m_cyc = 0; m_to = 0;
      return;
    end
    case (m_stage)
      S_IDLE: if (st) begin
        m_stage = S_LOAD; m_iter = 0; m_cyc = 0; m_to = 0;
      end
      S_LOAD: begin
        m_cyc   = (m_cyc < 65535) ? m_cyc + 1 : m_cyc;
        m_stage = S_SPREAD; m_quiet = 0;
      end
      S_SPREAD, S_SYNC: begin
        m_cyc   = (m_cyc < 65535) ? m_cyc + 1 : m_cyc;
        m_quiet = bsy ? 0 : m_quiet + 1;
        if (m_quiet == Q) begin
          m_quiet = 0;
          if (m_stage == S_SPREAD)      m_stage = S_SYNC;
          else if (!odd)                begin m_stage = S_RV; m_to = 0; end
          else if (m_iter == MAXI)      begin m_stage = S_RV; m_to = 1; end
          else                          m_stage = S_GROW;
        end
      end
      S_GROW: begin
        m_cyc   = (m_cyc < 65535) ? m_cyc + 1 : m_cyc;
        m_iter  = m_iter + 1;
        m_stage = S_SPREAD; m_quiet = 0;
      end
      S_RV: if (rdy) m_stage = S_IDLE;
      default: m_stage = S_IDLE;
    endcase
  endtask

  // Check the current cycle's outputs, then drive this cycle's inputs.
  task automatic cycle(input bit rst, input bit st, input bit bsy,
                       input bit odd, input bit rdy);
    @(negedge clk);
    check("stage",        32'(stage),             32'(m_stage));
    check("result_valid", 32'(result_valid),      32'(m_stage == S_RV));
    check("timeout",      32'(timeout),           32'(m_to));
    check("iteration",    32'(iteration_counter), 32'(m_iter));
    check("cycles",       32'(cycle_counter),     32'(m_cyc));
    if (cidx < 64) obs[cidx] = int'(stage);
    cidx++;
    reset = rst; start = st; busy_any = bsy; odd_cluster_any = odd; result_ready = rdy;
    model_step(rst, st, bsy, odd, rdy);
  endtask

  task automatic release_result();
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
  endtask

  // Plain decode: nothing busy, no odd clusters.
  task automatic plain_decode(input string tag);
    cidx = 0;
    cycle(1, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) cycle(1, 0, 0, 0, 0);
    check({tag, "_load"}, 32'(obs[1]), S_LOAD);
    for (int k = 2; k <= 4; k++) check({tag, "_spread"}, 32'(obs[k]), S_SPREAD);
    for (int k = 5; k <= 7; k++) check({tag, "_sync"}, 32'(obs[k]), S_SYNC);
    check({tag, "_rv"},   32'(obs[8]), S_RV);
    check({tag, "_iter"}, 32'(iteration_counter), 0);
    check({tag, "_cyc"},  32'(cycle_counter), 7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int grows;
    bit seen;

    reset = 1'b0; start = 1'b0; busy_any = 1'b0; odd_cluster_any = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, then a plain decode
    plain_decode("A");
    release_result();

    // One grow stage, odd clusters cleared after it
    cidx = 0;
    cycle(1, 1, 0, 0, 0);
    for (int k = 1; k <= 15; k++) cycle(1, 0, 0, (k <= 7), 0);
    check("B_grow",   32'(obs[8]),  S_GROW);
    check("B_sync2",  32'(obs[14]), S_SYNC);
    check("B_rv",     32'(obs[15]), S_RV);
    check("B_iter",   32'(iteration_counter), 1);
    check("B_cyc",    32'(cycle_counter), 14);
    check("B_to",     32'(timeout), 0);
    release_result();

    // Odd clusters never clear: timeout after MAXI grows
    grows = 0; seen = 0; cidx = 0;
    cycle(1, 1, 0, 1, 0);
    for (int k = 1; k <= 60; k++) begin
      cycle(1, 0, 0, 1, 0);
      if (stage == 3'(S_GROW)) grows++;
      if (result_valid) begin seen = 1; break; end
    end
    check("C_wait_rv", 32'(seen), 1);
    check("C_grows",   32'(grows), MAXI);
    check("C_to",      32'(timeout), 1);
    check("C_iter",    32'(iteration_counter), MAXI);
    check("C_rv_at",   32'(cidx - 1), 22);
    release_result();

    // Busy pulse in cycle 3 stretches SPREAD
    cidx = 0;
    cycle(1, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) cycle(1, 0, (k == 3), 0, 0);
    for (int k = 2; k <= 6; k++) check("D_spread", 32'(obs[k]), S_SPREAD);
    check("D_sync", 32'(obs[7]), S_SYNC);
    check("D_rv",   32'(obs[10]), S_RV);
    release_result();

    // Back-pressure with stray starts; start together with handshake
    cidx = 0;
    cycle(1, 1, 0, 0, 0);
    for (int k = 1; k <= 18; k++) cycle(1, (k == 3) || (k == 12), 0, 0, 0);
    check("E_rv_hold",  32'(result_valid), 1);
    check("E_cyc_hold", 32'(cycle_counter), 7);
    check("E_load_once", 32'(obs[4]), S_SPREAD);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    check("E_idle", 32'(stage), S_IDLE);
    cycle(1, 0, 0, 0, 0);
    check("E_start_ignored", 32'(stage), S_IDLE);
    check("E_cyc_idle_hold", 32'(cycle_counter), 7);

    // Reset mid-decode, then a clean replay
    cidx = 0;
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("F_pre_reset",  32'(obs[3]), S_SPREAD);
    check("F_stage0",     32'(stage), S_IDLE);
    check("F_cyc0",       32'(cycle_counter), 0);
    check("F_iter0",      32'(iteration_counter), 0);
    plain_decode("F");
    release_result();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 1) == 0));
    end
    cycle(1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_stage_controller.md
DECODER_STAGE_CONTROLLER -- requirements
Module: decoder_stage_controller

Interface
REQ-001 SHALL have parameter CODE_DISTANCE, default 5, code distance of the decoder array.
REQ-002 SHALL have parameter QUIESCE_CYCLES, default 3, consecutive quiet cycles that end a settling stage; range 1..15.
REQ-003 SHALL have parameter MAX_ITERATION, default 2*CODE_DISTANCE, grow-iteration limit; range 1..255.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; synchronous, active-low.
REQ-006 SHALL have port start, input, 1, request to decode the syndrome currently presented to the processing units.
REQ-007 SHALL have port busy_any, input, 1, OR of all PU is_processing and channel valid bits.
REQ-008 SHALL have port odd_cluster_any, input, 1, OR over PUs of is_odd_cluster AND NOT is_touching_boundary.
REQ-009 SHALL have port result_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port stage, output, STAGE_WIDTH, registered stage broadcast to every PU stage_in.
REQ-011 SHALL have port result_valid, output, 1, decode finished; result stable.
REQ-012 SHALL have port timeout, output, 1, qualified by result_valid; MAX_ITERATION reached with odd clusters left.
REQ-013 SHALL have port iteration_counter, output, 8, count of GROW_BOUNDARY stages issued.
REQ-014 SHALL have port cycle_counter, output, 16, active decode cycles.

Function
REQ-015 SHALL implement states IDLE, MEASUREMENT_LOADING, SPREAD_CLUSTER, SYNC_IS_ODD_CLUSTER, GROW_BOUNDARY, RESULT_VALID; stage output equals the current state encoding.
REQ-016 IDLE: start=1 SHALL move to MEASUREMENT_LOADING next cycle and clear iteration_counter, cycle_counter, timeout; start is ignored in all other states.
REQ-017 MEASUREMENT_LOADING SHALL last exactly 1 cycle, then SPREAD_CLUSTER.
REQ-018 SPREAD_CLUSTER and SYNC_IS_ODD_CLUSTER: quiet count cleared on stage entry and on any cycle with busy_any=1; incremented on each cycle with busy_any=0; stage exits in the cycle the count reaches QUIESCE_CYCLES.
REQ-019 SPREAD_CLUSTER exit SHALL go to SYNC_IS_ODD_CLUSTER.
REQ-020 SYNC_IS_ODD_CLUSTER exit SHALL sample odd_cluster_any in the exit cycle: 0 -> RESULT_VALID, timeout=0; 1 with iteration_counter==MAX_ITERATION -> RESULT_VALID, timeout=1; otherwise -> GROW_BOUNDARY.
REQ-021 GROW_BOUNDARY SHALL last exactly 1 cycle, increment iteration_counter, then SPREAD_CLUSTER.
REQ-022 cycle_counter SHALL increment in every MEASUREMENT_LOADING, SPREAD_CLUSTER, SYNC_IS_ODD_CLUSTER and GROW_BOUNDARY cycle, saturating at 16'hFFFF.
REQ-023 result_valid SHALL be 1 exactly in RESULT_VALID; result_valid AND result_ready -> IDLE next cycle.
REQ-024 iteration_counter, cycle_counter and timeout SHALL hold while in RESULT_VALID and IDLE until the next accepted start.
REQ-025 A start coinciding with the result_ready handshake SHALL be ignored.
REQ-026 There SHALL be no combinational path from any input to any output.

Reset
REQ-027 reset=0 at a clk edge SHALL force IDLE from any state, including mid-decode, and zero stage, result_valid, timeout, iteration_counter, cycle_counter and the quiet count.

Structure
REQ-028 Stage encodings (IDLE=0, MEASUREMENT_LOADING=1, SPREAD_CLUSTER=2, SYNC_IS_ODD_CLUSTER=3, GROW_BOUNDARY=4, RESULT_VALID=5) and STAGE_WIDTH=3 SHALL live in the shared decoder parameters package, also used by processing units.
REQ-029 Quiet counting SHALL be one sub-module, quiescence_counter (inputs clear, busy; output done).

Verification (QUIESCE_CYCLES=3 unless stated; start sampled at cycle 0)
REQ-030 busy_any=0, odd_cluster_any=0 -> LOAD at cycle 1, SPREAD 2-4, SYNC 5-7, result_valid at 8, iteration_counter=0, cycle_counter=7.
REQ-031 odd_cluster_any=1 through the first SYNC, then 0 -> one GROW_BOUNDARY at cycle 8; result_valid at 15; iteration_counter=1, cycle_counter=14, timeout=0.
REQ-032 MAX_ITERATION=2, odd_cluster_any held 1 -> exactly two GROW_BOUNDARY stages; result_valid with timeout=1, iteration_counter=2.
REQ-033 busy_any=1 in cycle 3 only -> SPREAD holds cycles 2-6; SYNC at cycle 7.
REQ-034 result_ready=0 for 10 cycles -> result_valid and counters hold; start pulses during decode and in RESULT_VALID ignored; result_ready=1 -> IDLE next cycle.
REQ-035 reset=0 during SPREAD_CLUSTER -> stage=0 and all counters 0 next cycle; a following start replays the REQ-030 timing.
